// File: rtl/gate_motion_sequencer.sv
// Gate servo sequencer: slew-limited pulse-width ramp between closed and open, with presence-driven reversal.
// Optional timed auto-close from OPEN is enabled by defining GATE_AUTOCLOSE_EN.
module gate_motion_sequencer #(
  parameter int PULSO_W      = 16,
  parameter int PULSE_CLOSED = 25_000,
  parameter int PULSE_OPEN   = 50_000,
  parameter int STEP         = 250,
  parameter int HOLD_FRAMES  = 150
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               open_req,
  input  logic               presence,
  input  logic               frame_tick,
  output logic [PULSO_W-1:0] pulse_cycles,
  output logic [1:0]         gate_state,
  output logic               busy
);

  typedef enum logic [1:0] {
    ST_CLOSED  = 2'd0,
    ST_OPENING = 2'd1,
    ST_OPEN    = 2'd2,
    ST_CLOSING = 2'd3
  } state_t;

  localparam logic [PULSO_W-1:0] OPEN_W   = PULSO_W'(PULSE_OPEN);
  localparam logic [PULSO_W-1:0] CLOSED_W = PULSO_W'(PULSE_CLOSED);
  localparam logic [PULSO_W:0]   OPEN_X   = (PULSO_W+1)'(PULSE_OPEN);
  localparam logic [PULSO_W:0]   CLOSED_X = (PULSO_W+1)'(PULSE_CLOSED);
  localparam logic [PULSO_W:0]   STEP_X   = (PULSO_W+1)'(STEP);

  // Misconfigured ramp limits would let the arithmetic wrap; stop elaboration instead.
  if (PULSE_OPEN <= PULSE_CLOSED || PULSE_OPEN >= (1 << PULSO_W) || STEP < 1 || HOLD_FRAMES < 1) begin : g_bad_params
    $error("gate_motion_sequencer: invalid parameter set");
  end

  state_t             state_r;
  state_t             state_s;
  logic [PULSO_W-1:0] pulse_r;
  logic [PULSO_W-1:0] pulse_s;
  logic               busy_r;
  logic [PULSO_W:0]   pulse_x_s;
  logic [PULSO_W:0]   up_s;
  logic [PULSO_W:0]   dn_s;
  logic               at_open_s;
  logic               at_closed_s;
  logic               expire_s;

  // Add/subtract one step in the widened domain so neither edge of the range can wrap.
  function automatic logic [PULSO_W:0] step_up(input logic [PULSO_W:0] cur);
    return cur + STEP_X;
  endfunction

  function automatic logic [PULSO_W:0] step_dn(input logic [PULSO_W:0] cur);
    return cur - STEP_X;
  endfunction

  assign pulse_x_s   = {1'b0, pulse_r};
  assign up_s        = step_up(pulse_x_s);
  assign dn_s        = step_dn(pulse_x_s);
  assign at_open_s   = (OPEN_X - pulse_x_s) <= STEP_X;
  assign at_closed_s = (pulse_x_s - CLOSED_X) <= STEP_X;

`ifdef GATE_AUTOCLOSE_EN
  localparam int               HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_X = HOLD_W'(HOLD_FRAMES);

  logic [HOLD_W-1:0] hold_r;
  logic [HOLD_W-1:0] hold_s;

  // Hold countdown: loaded on arrival at OPEN and by presence, counted down by idle frames.
  always_comb begin
    hold_s   = hold_r;
    expire_s = 1'b0;
    if (state_r == ST_OPENING && frame_tick && at_open_s) begin
      hold_s = HOLD_X;
    end else if (state_r == ST_OPEN) begin
      if (presence) begin
        hold_s = HOLD_X;
      end else if (frame_tick && hold_r != {HOLD_W{1'b0}}) begin
        hold_s   = hold_r - HOLD_W'(1);
        expire_s = (hold_r == HOLD_W'(1));
      end else begin
        hold_s = hold_r;
      end
    end else begin
      hold_s = hold_r;
    end
  end

  // Hold counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r <= {HOLD_W{1'b0}};
    end else begin
      hold_r <= hold_s;
    end
  end
`else
  assign expire_s = 1'b0;
`endif

  // Next-state and next pulse width; reversal in CLOSING outranks a same-cycle frame tick.
  always_comb begin
    state_s = state_r;
    pulse_s = pulse_r;
    case (state_r)
      ST_CLOSED: begin
        if (open_req) begin
          state_s = ST_OPENING;
        end else begin
          state_s = ST_CLOSED;
        end
      end
      ST_OPENING: begin
        if (frame_tick) begin
          if (at_open_s) begin
            pulse_s = OPEN_W;
            state_s = ST_OPEN;
          end else begin
            pulse_s = up_s[PULSO_W-1:0];
          end
        end else begin
          state_s = ST_OPENING;
        end
      end
      ST_OPEN: begin
        pulse_s = OPEN_W;
        if ((open_req && !presence) || expire_s) begin
          state_s = ST_CLOSING;
        end else begin
          state_s = ST_OPEN;
        end
      end
      ST_CLOSING: begin
        if (presence || open_req) begin
          state_s = ST_OPENING;
        end else if (frame_tick) begin
          if (at_closed_s) begin
            pulse_s = CLOSED_W;
            state_s = ST_CLOSED;
          end else begin
            pulse_s = dn_s[PULSO_W-1:0];
          end
        end else begin
          state_s = ST_CLOSING;
        end
      end
      default: begin
        state_s = ST_CLOSED;
        pulse_s = CLOSED_W;
      end
    endcase
  end

  // State, pulse command and busy flag registers; reset snaps the gate shut.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_CLOSED;
      pulse_r <= CLOSED_W;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      pulse_r <= pulse_s;
      busy_r  <= (state_s == ST_OPENING) || (state_s == ST_CLOSING);
    end
  end

  assign pulse_cycles = pulse_r;
  assign gate_state   = state_r;
  assign busy         = busy_r;

endmodule
